// File: rtl/serial_subtractor_16bit.sv
// Bit-serial a - b - bin, one bit per cycle LSB first, with valid/ready on
// both the operand side and the result side.
module serial_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic x, y, d, br_next;

  always_comb begin
    x       = a_sh_q[0];
    y       = b_sh_q[0];
    d       = x ^ y ^ br_q;
    br_next = (~x & y) | (~(x ^ y) & br_q);

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    work_d  = work_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Difference bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
        work_d = {d, work_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        br_d   = br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d  = work_d;
          bout_d  = br_next;
          zero_d  = (work_d == '0);
          neg_d   = work_d[WIDTH-1];
          ovf_d   = (a_msb_q != b_msb_q) && (work_d[WIDTH-1] != a_msb_q);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      work_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      work_q  <= work_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Directed bench for serial_subtractor_16bit: arithmetic, latency,
// backpressure and mid-operation reset.
module tb_serial_subtractor_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int checks;
  int failures;

  serial_subtractor_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges from the accept edge until out_valid, bounded at 40.
  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    chk({tag, "_latency"}, lat, 16);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ibin, input logic [15:0] ed, input logic eb,
                        input logic ez, input logic en, input logic eo);
    chk({tag, "_in_ready"}, in_ready, 1);
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result(tag);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_neg"},  neg,  en);
    chk({tag, "_ovf"},  ovf,  eo);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_out_valid"}, out_valid, 0);
    chk({tag, "_idle_in_ready"},  in_ready,  1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_diff",      diff,      0);
    chk("rst_flags",     {bout, zero, neg, ovf}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_op("sub_5_3",      16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_0_1",      16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_8000_1",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("sub_zero_bin", 16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_0_ffff_1", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: result held while new operands are offered and refused.
    a = 16'h0005; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_result("bp_first");
    a = 16'hFFFF; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready",  in_ready,  0);
      chk("bp_diff",      diff,      16'h0002);
      chk("bp_flags",     {bout, zero, neg, ovf}, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready",  in_ready,  1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept_in_ready", in_ready, 0);
    wait_result("bp_second");
    chk("bp_second_diff", diff, 16'hFFFF);
    chk("bp_second_flags", {bout, zero, neg, ovf}, 4'b0010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation.
    a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_run_out_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_diff",      diff,      0);
    chk("mid_rst_in_ready",  in_ready,  1);
    tick();
    rst_n = 1'b1;
    run_op("post_rst", 16'h0100, 16'h00FF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
